// File: rtl/i2c_wb_master.sv
// i2c_wb_master: turns single-cycle read/write strobes from the I2C sequencer
// into Wishbone classic single cycles toward the I2C controller core, with an
// ack timeout and sticky error/overrun reporting.
//
// Handshake: the sequencer's strobe is accepted only when wb_done is high in the
// same cycle. wb_done falls combinationally while a strobe is presented, and
// rises again the cycle after the bus cycle ends (ack, err or timeout). On the
// Wishbone side, cyc/stb/we/adr/dat stay stable from acceptance until the edge
// at which ack or err is sampled, or until the timeout forces the cycle to end.
module i2c_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_read,
    input  logic       wb_write,
    input  logic [3:0] wb_address,
    input  logic [7:0] wb_data_out,
    output logic [7:0] wb_data_in,
    output logic       wb_data_in_valid,
    output logic       wb_done,
    output logic       wbm_cyc_o,
    output logic       wbm_stb_o,
    output logic       wbm_we_o,
    output logic [3:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    input  logic       wbm_ack_i,
    input  logic       wbm_err_i,
    output logic       bus_error,
    output logic       req_overrun
);

    typedef enum logic {ST_IDLE = 1'b0, ST_CYCLE = 1'b1} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [3:0]       adr_q, adr_d;
    logic [7:0]       dat_q, dat_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             bus_error_q, bus_error_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state and bus-control decisions; every target defaults to hold.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rdata_d     = rdata_q;
        rvalid_d    = rvalid_q;
        bus_error_d = bus_error_q;
        overrun_d   = overrun_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (wb_write) begin
                    // A simultaneous read is dropped; the write takes the bus.
                    state_d = ST_CYCLE;
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = wb_address;
                    dat_d   = wb_data_out;
                    cnt_d   = '0;
                    if (wb_read) overrun_d = 1'b1;
                end else if (wb_read) begin
                    state_d  = ST_CYCLE;
                    cyc_d    = 1'b1;
                    we_d     = 1'b0;
                    adr_d    = wb_address;
                    dat_d    = wb_data_out;
                    cnt_d    = '0;
                    rvalid_d = 1'b0;
                end
            end
            ST_CYCLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (wb_read || wb_write) overrun_d = 1'b1;
                if (wbm_err_i) begin
                    // Error termination wins over a simultaneous ack.
                    state_d     = ST_IDLE;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    bus_error_d = 1'b1;
                end else if (wbm_ack_i) begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        rdata_d  = wbm_dat_i;
                        rvalid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Hung slave: abandon the cycle so the sequencer can move on.
                    state_d     = ST_IDLE;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    bus_error_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            bus_error_q <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            bus_error_q <= bus_error_d;
            overrun_q   <= overrun_d;
            cnt_q       <= cnt_d;
        end
    end

    // Done drops in the strobe cycle so a stale done is never seen.
    always_comb begin
        wb_done = (state_q == ST_IDLE) && !wb_read && !wb_write;
    end

    assign wbm_cyc_o        = cyc_q;
    assign wbm_stb_o        = cyc_q;
    assign wbm_we_o         = we_q;
    assign wbm_adr_o        = adr_q;
    assign wbm_dat_o        = dat_q;
    assign wb_data_in       = rdata_q;
    assign wb_data_in_valid = rvalid_q;
    assign bus_error        = bus_error_q;
    assign req_overrun      = overrun_q;

endmodule

// File: tb/tb_i2c_wb_master.sv
// Directed bench for i2c_wb_master with a short timeout (8 cycles).
module tb_i2c_wb_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       wb_read, wb_write;
    logic [3:0] wb_address;
    logic [7:0] wb_data_out;
    logic [7:0] wb_data_in;
    logic       wb_data_in_valid, wb_done;
    logic       wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0] wbm_adr_o;
    logic [7:0] wbm_dat_o;
    logic [7:0] wbm_dat_i;
    logic       wbm_ack_i, wbm_err_i;
    logic       bus_error, req_overrun;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_rd;

    i2c_wb_master #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .wb_read(wb_read), .wb_write(wb_write),
        .wb_address(wb_address), .wb_data_out(wb_data_out),
        .wb_data_in(wb_data_in), .wb_data_in_valid(wb_data_in_valid),
        .wb_done(wb_done),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .bus_error(bus_error), .req_overrun(req_overrun)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a one-cycle request; caller checks done before the accepting edge.
    task automatic drive_req(input logic rd, input logic wr, input logic [3:0] a, input logic [7:0] d);
        wb_read     = rd;
        wb_write    = wr;
        wb_address  = a;
        wb_data_out = d;
        #1;
    endtask

    task automatic release_req();
        wb_read  = 1'b0;
        wb_write = 1'b0;
    endtask

    task automatic chk_bus(input string tag, input logic cyc, input logic we, input logic [3:0] a, input logic [7:0] d);
        chk({tag, "_cyc"}, wbm_cyc_o, cyc);
        chk({tag, "_stb"}, wbm_stb_o, cyc);
        chk({tag, "_we"}, wbm_we_o, we);
        chk({tag, "_adr"}, wbm_adr_o, a);
        chk({tag, "_dat"}, wbm_dat_o, d);
    endtask

    initial begin
        reset = 1'b1;
        wb_read = 1'b0; wb_write = 1'b0; wb_address = '0; wb_data_out = '0;
        wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;

        // Reset state
        chk_bus("rst", 1'b0, 1'b0, 4'h0, 8'h00);
        chk("rst_rdata", wb_data_in, 8'h00);
        chk("rst_valid", wb_data_in_valid, 1'b0);
        chk("rst_berr", bus_error, 1'b0);
        chk("rst_ovr", req_overrun, 1'b0);
        chk("rst_done", wb_done, 1'b1);

        // Write 0x34 to ADDR, ack after 3 cycles
        tick();
        drive_req(1'b0, 1'b1, 4'h2, 8'h34);
        chk("w1_done_strobe", wb_done, 1'b0);
        tick(); release_req(); #1;
        chk_bus("w1_c1", 1'b1, 1'b1, 4'h2, 8'h34);
        chk("w1_done_c1", wb_done, 1'b0);
        tick();
        chk_bus("w1_c2", 1'b1, 1'b1, 4'h2, 8'h34);
        tick();
        chk_bus("w1_c3", 1'b1, 1'b1, 4'h2, 8'h34);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        chk("w1_cyc_end", wbm_cyc_o, 1'b0);
        chk("w1_we_end", wbm_we_o, 1'b0);
        chk("w1_done_end", wb_done, 1'b1);
        chk("w1_valid", wb_data_in_valid, 1'b0);

        // Read STS with ack on first cycle
        exp_q.push_back(8'h01);
        drive_req(1'b1, 1'b0, 4'h0, 8'h00);
        chk("r1_done_strobe", wb_done, 1'b0);
        tick(); release_req(); #1;
        chk_bus("r1_c1", 1'b1, 1'b0, 4'h0, 8'h00);
        chk("r1_done_c1", wb_done, 1'b0);
        wbm_ack_i = 1'b1; wbm_dat_i = 8'h01;
        tick();
        wbm_ack_i = 1'b0; wbm_dat_i = 8'hff;
        exp_rd = exp_q.pop_front();
        chk("r1_rdata", wb_data_in, exp_rd);
        chk("r1_valid", wb_data_in_valid, 1'b1);
        chk("r1_cyc_end", wbm_cyc_o, 1'b0);
        chk("r1_done_end", wb_done, 1'b1);

        // A following write leaves read data alone
        drive_req(1'b0, 1'b1, 4'h3, 8'h55);
        tick(); release_req(); #1;
        chk_bus("w2_c1", 1'b1, 1'b1, 4'h3, 8'h55);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        chk("w2_rdata", wb_data_in, 8'h01);
        chk("w2_valid", wb_data_in_valid, 1'b1);
        chk("w2_done", wb_done, 1'b1);

        // Read terminated by ack and err together: err wins
        chk("ae_berr_before", bus_error, 1'b0);
        drive_req(1'b1, 1'b0, 4'h4, 8'h00);
        tick(); release_req(); #1;
        chk("ae_valid_cleared", wb_data_in_valid, 1'b0);
        wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_dat_i = 8'h77;
        tick();
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        chk("ae_berr", bus_error, 1'b1);
        chk("ae_valid", wb_data_in_valid, 1'b0);
        chk("ae_rdata_kept", wb_data_in, 8'h01);
        chk("ae_cyc_end", wbm_cyc_o, 1'b0);
        chk("ae_done", wb_done, 1'b1);

        // Read with no ack: cyc held exactly 8 cycles then timeout
        drive_req(1'b1, 1'b0, 4'h4, 8'h00);
        tick(); release_req(); #1;
        chk("to_cyc_1", wbm_cyc_o, 1'b1);
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk($sformatf("to_cyc_%0d", i), wbm_cyc_o, 1'b1);
        end
        tick();
        chk("to_cyc_end", wbm_cyc_o, 1'b0);
        chk("to_stb_end", wbm_stb_o, 1'b0);
        chk("to_berr", bus_error, 1'b1);
        chk("to_valid", wb_data_in_valid, 1'b0);
        chk("to_done", wb_done, 1'b1);

        // Write strobe during an active read, then read+write together
        chk("ov_before", req_overrun, 1'b0);
        exp_q.push_back(8'h3c);
        drive_req(1'b1, 1'b0, 4'h0, 8'h00);
        tick();
        drive_req(1'b0, 1'b1, 4'h3, 8'hee);
        tick(); release_req(); #1;
        chk("ov_set", req_overrun, 1'b1);
        chk_bus("ov_inflight", 1'b1, 1'b0, 4'h0, 8'h00);
        wbm_ack_i = 1'b1; wbm_dat_i = 8'h3c;
        tick();
        wbm_ack_i = 1'b0;
        exp_rd = exp_q.pop_front();
        chk("ov_rdata", wb_data_in, exp_rd);
        chk("ov_valid", wb_data_in_valid, 1'b1);
        chk("ov_cyc_end", wbm_cyc_o, 1'b0);
        tick();
        chk("ov_no_extra_cyc", wbm_cyc_o, 1'b0);
        drive_req(1'b1, 1'b1, 4'h2, 8'h99);
        chk("rw_done_strobe", wb_done, 1'b0);
        tick(); release_req(); #1;
        chk_bus("rw_c1", 1'b1, 1'b1, 4'h2, 8'h99);
        wbm_ack_i = 1'b1; wbm_dat_i = 8'h11;
        tick();
        wbm_ack_i = 1'b0;
        chk("rw_rdata", wb_data_in, 8'h3c);
        chk("rw_valid", wb_data_in_valid, 1'b1);
        chk("rw_ovr", req_overrun, 1'b1);

        // Reset two cycles into a cycle with ack pending
        drive_req(1'b0, 1'b1, 4'h3, 8'h12);
        tick(); release_req(); #1;
        tick();
        chk("rs_cyc_before", wbm_cyc_o, 1'b1);
        reset = 1'b1; wbm_ack_i = 1'b1;
        tick();
        reset = 1'b0; wbm_ack_i = 1'b0;
        #1;
        chk_bus("rs", 1'b0, 1'b0, 4'h0, 8'h00);
        chk("rs_rdata", wb_data_in, 8'h00);
        chk("rs_valid", wb_data_in_valid, 1'b0);
        chk("rs_berr", bus_error, 1'b0);
        chk("rs_ovr", req_overrun, 1'b0);
        chk("rs_done", wb_done, 1'b1);
        tick();
        chk("rs_valid_later", wb_data_in_valid, 1'b0);
        chk("rs_cyc_later", wbm_cyc_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_wb_master.md
Name: i2c_wb_master

Overview:
- Downstream stage of the I2C sequencer: turns its single-cycle wb_read/wb_write strobes into Wishbone classic single read/write cycles to the I2C controller core (registers STS=0x0, ADDR=0x2, CMD=0x3, DATA=0x4).
- Returns completion (wb_done), read data and a data-valid flag to the sequencer.
- Adds an ack timeout and error reporting so that a hung core cannot stall the codec unit.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles allowed from cycle start to ack/err before forced termination; legal range 2..65535.
- CNT_W, 16, width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wb_read  in  1  1-cycle read request strobe from the sequencer
- wb_write  in  1  1-cycle write request strobe from the sequencer
- wb_address  in  4  target register address
- wb_data_out  in  8  write data from the sequencer
- wb_data_in  out  8  captured read data
- wb_data_in_valid  out  1  wb_data_in holds data from the most recent completed read
- wb_done  out  1  bridge idle/complete (level)
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_adr_o  out  4  Wishbone address
- wbm_dat_o  out  8  Wishbone write data
- wbm_dat_i  in  8  Wishbone read data
- wbm_ack_i  in  1  Wishbone ack
- wbm_err_i  in  1  Wishbone error termination
- bus_error  out  1  sticky: err_i or timeout seen; cleared only by reset
- req_overrun  out  1  sticky: request while busy, or read and write together; cleared only by reset

Behaviour:
- Reset (synchronous, active-high): state IDLE.
  - wbm_cyc_o, wbm_stb_o, wbm_we_o = 0; wbm_adr_o = 0; wbm_dat_o = 0.
  - wb_data_in = 0, wb_data_in_valid = 0, bus_error = 0, req_overrun = 0, counter = 0.
  - wb_done follows its equation (= 1 with no strobe).
  - Reset during an active cycle drops cyc/stb on the next edge; no completion is reported.
- wb_done is combinational: (state==IDLE) && !wb_read && !wb_write. It falls in the same cycle a strobe is presented, so the sequencer's wait state cannot advance on a stale done.
- States:
  - IDLE:
    - On wb_write: latch wb_address into wbm_adr_o and wb_data_out into wbm_dat_o; drive cyc=stb=we=1; clear counter; go to CYCLE.
    - On wb_read: same, but we=0 and wb_data_in_valid is cleared; go to CYCLE.
    - Otherwise outputs are held.
  - CYCLE:
    - cyc/stb/we/adr/dat are held stable. The counter increments each cycle.
    - On wbm_ack_i=1: drop cyc/stb/we at that edge and go to IDLE. For a read, capture wbm_dat_i into wb_data_in and set wb_data_in_valid=1 at that same edge.
    - On wbm_err_i=1 (priority over ack when both are high): drop cyc/stb, set bus_error, wb_data_in_valid stays 0, go to IDLE.
    - When counter == TIMEOUT_CYCLES-1 with no ack/err: drop cyc/stb, set bus_error, wb_data_in_valid stays 0, go to IDLE.
- Latency: strobe sampled at edge E0, so cyc/stb are high from E0. With ack sampled at edge Ek, wb_done=1 in the cycle after Ek. Minimum request-to-done is 2 cycles (ack on the first cycle of the bus cycle).
- wb_data_in and wb_data_in_valid hold until the next accepted read; writes do not disturb them.
- Strobes seen while in CYCLE are dropped and set req_overrun. wb_read and wb_write high together: the write is performed, the read is dropped, req_overrun is set.
- Exactly one Wishbone cycle per accepted request. No back-to-back reuse of cyc: at least one idle cycle between bus cycles.

Test Plan:
- Write 0x34 to addr 0x2, ack after 3 cycles -> cyc/stb/we=1 with adr=0x2, dat=0x34 held for 3 cycles; wb_done low in the strobe cycle, high 1 cycle after ack; wb_data_in_valid unchanged.
- Read addr 0x0, wbm_dat_i=0x01 with ack on the first cycle -> we=0; wb_data_in=0x01, valid=1 on the ack edge; done high 2 cycles after the strobe; a following write leaves valid=1 and data 0x01.
- Read with no ack, TIMEOUT_CYCLES=8 -> cyc drops after exactly 8 cycles, bus_error=1, wb_data_in_valid=0, wb_done returns high.
- Read, slave asserts ack and err together -> err wins: bus_error=1, valid=0, wb_data_in keeps its previous value.
- wb_write strobe during an active read cycle, plus wb_read+wb_write together in IDLE -> in-flight read completes untouched; the combined strobe produces a write only; req_overrun=1.
- Assert reset 2 cycles into a cycle with ack pending -> cyc/stb/we low on the next edge, all outputs at reset values, wb_done=1, no valid pulse.
